// File: rtl/color_pkg.sv
// Shared constants for the grayscale converter: mode encoding, BT.601 defaults
// and the fixed equal-weight set used by the average mode.
package color_pkg;

    typedef enum logic [1:0] {
        MODE_WEIGHTED = 2'd0,
        MODE_AVG      = 2'd1,
        MODE_MAX      = 2'd2,
        MODE_GREEN    = 2'd3
    } gray_mode_e;

    localparam int BT601_R = 77;
    localparam int BT601_G = 150;
    localparam int BT601_B = 29;

    localparam int AVG_R = 85;
    localparam int AVG_G = 85;
    localparam int AVG_B = 86;

    // Weights above are expressed with 8 fractional bits; rescale to another format.
    function automatic int scale_coef(input int w, input int frac);
        if (frac >= 8) begin
            return w << (frac - 8);
        end
        return w >> (8 - frac);
    endfunction

endpackage

// File: rtl/gray_round_sat.sv
// Combinational round-to-nearest, right shift by SH and saturation to OUT_W bits.
module gray_round_sat #(
    parameter int IN_W  = 18,
    parameter int SH    = 8,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  value,
    output logic [OUT_W-1:0] result
);

    localparam int EW = IN_W + 1;
    localparam logic [EW-1:0] MAX_OUT = EW'((1 << OUT_W) - 1);

    logic [EW-1:0] shifted;

    generate
        if (SH > 0) begin : g_round
            logic [EW-1:0] biased;
            assign biased  = {1'b0, value} + (EW'(1) << (SH - 1));
            assign shifted = biased >> SH;
        end else begin : g_noround
            assign shifted = {1'b0, value};
        end
    endgenerate

    always_comb begin
        result = shifted[OUT_W-1:0];
        if (shifted > MAX_OUT) begin
            result = '1;
        end
    end

endmodule

// File: rtl/color_to_grayscale_stream.sv
// Three-stage RGB to grayscale stream converter with frame-aligned configuration
// updates and a global valid/ready stall.
module color_to_grayscale_stream
    import color_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter int OUT_W     = 8,
    parameter int COEF_W    = 8,
    parameter int COEF_FRAC = 8,
    parameter int DEF_R     = BT601_R,
    parameter int DEF_G     = BT601_G,
    parameter int DEF_B     = BT601_B
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_mode,
    input  logic [COEF_W-1:0] cfg_coef_r,
    input  logic [COEF_W-1:0] cfg_coef_g,
    input  logic [COEF_W-1:0] cfg_coef_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_r,
    input  logic [IN_W-1:0]   in_g,
    input  logic [IN_W-1:0]   in_b,
    input  logic              in_sof,
    input  logic              in_eol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_gray,
    output logic              out_sof,
    output logic              out_eol,
    output logic [1:0]        active_mode
);

    localparam int P_W = IN_W + COEF_W;
    localparam int S_W = P_W + 2;
    localparam int SH  = COEF_FRAC + IN_W - OUT_W;
    localparam int MSH = IN_W - OUT_W;

    localparam logic [COEF_W-1:0] AVG_CR = COEF_W'(scale_coef(AVG_R, COEF_FRAC));
    localparam logic [COEF_W-1:0] AVG_CG = COEF_W'(scale_coef(AVG_G, COEF_FRAC));
    localparam logic [COEF_W-1:0] AVG_CB = COEF_W'(scale_coef(AVG_B, COEF_FRAC));

    logic advance;
    logic accept;
    logic load_act;

    logic [1:0]        pend_mode, act_mode, src_mode, eff_mode;
    logic [COEF_W-1:0] pend_cr, pend_cg, pend_cb;
    logic [COEF_W-1:0] act_cr, act_cg, act_cb;
    logic [COEF_W-1:0] src_cr, src_cg, src_cb;
    logic [COEF_W-1:0] use_cr, use_cg, use_cb;

    logic              s1_valid, s1_sof, s1_eol;
    logic [1:0]        s1_mode;
    logic [IN_W-1:0]   s1_r, s1_g, s1_b;
    logic [COEF_W-1:0] s1_cr, s1_cg, s1_cb;

    logic              s2_valid, s2_sof, s2_eol;
    logic [1:0]        s2_mode;
    logic [P_W-1:0]    s2_pr, s2_pg, s2_pb;
    logic [IN_W-1:0]   s2_m;
    logic [IN_W-1:0]   max_rg, max_rgb;

    logic              s3_valid, s3_sof, s3_eol;
    logic [1:0]        s3_mode;
    logic [S_W-1:0]    s3_sum;
    logic [IN_W-1:0]   s3_m;

    logic [OUT_W-1:0]  rs_gray;
    logic [OUT_W-1:0]  pick_gray;

    assign advance     = !(out_valid && !out_ready);
    assign in_ready    = advance;
    assign accept      = in_valid && in_ready;
    assign load_act    = accept && in_sof;
    assign active_mode = act_mode;

    // The sof pixel sees a same-cycle write directly, otherwise the pending set.
    always_comb begin
        src_mode = pend_mode;
        src_cr   = pend_cr;
        src_cg   = pend_cg;
        src_cb   = pend_cb;
        if (cfg_we) begin
            src_mode = cfg_mode;
            src_cr   = cfg_coef_r;
            src_cg   = cfg_coef_g;
            src_cb   = cfg_coef_b;
        end
        eff_mode = load_act ? src_mode : act_mode;
        use_cr   = load_act ? src_cr : act_cr;
        use_cg   = load_act ? src_cg : act_cg;
        use_cb   = load_act ? src_cb : act_cb;
        if (eff_mode == MODE_AVG) begin
            use_cr = AVG_CR;
            use_cg = AVG_CG;
            use_cb = AVG_CB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_mode <= MODE_WEIGHTED;
            pend_cr   <= COEF_W'(DEF_R);
            pend_cg   <= COEF_W'(DEF_G);
            pend_cb   <= COEF_W'(DEF_B);
            act_mode  <= MODE_WEIGHTED;
            act_cr    <= COEF_W'(DEF_R);
            act_cg    <= COEF_W'(DEF_G);
            act_cb    <= COEF_W'(DEF_B);
        end else begin
            if (cfg_we) begin
                pend_mode <= cfg_mode;
                pend_cr   <= cfg_coef_r;
                pend_cg   <= cfg_coef_g;
                pend_cb   <= cfg_coef_b;
            end
            if (load_act) begin
                act_mode <= src_mode;
                act_cr   <= src_cr;
                act_cg   <= src_cg;
                act_cb   <= src_cb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else if (advance) begin
            s1_valid <= accept;
            s1_r     <= in_r;
            s1_g     <= in_g;
            s1_b     <= in_b;
            s1_sof   <= in_sof;
            s1_eol   <= in_eol;
            s1_mode  <= eff_mode;
            s1_cr    <= use_cr;
            s1_cg    <= use_cg;
            s1_cb    <= use_cb;
        end
    end

    always_comb begin
        max_rg  = (s1_r > s1_g) ? s1_r : s1_g;
        max_rgb = (max_rg > s1_b) ? max_rg : s1_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            s2_pr    <= P_W'(s1_r) * P_W'(s1_cr);
            s2_pg    <= P_W'(s1_g) * P_W'(s1_cg);
            s2_pb    <= P_W'(s1_b) * P_W'(s1_cb);
            s2_m     <= (s1_mode == MODE_MAX) ? max_rgb : s1_g;
            s2_mode  <= s1_mode;
            s2_sof   <= s1_sof;
            s2_eol   <= s1_eol;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_valid <= 1'b0;
        end else if (advance) begin
            s3_valid <= s2_valid;
            s3_sum   <= S_W'(s2_pr) + S_W'(s2_pg) + S_W'(s2_pb);
            s3_m     <= s2_m;
            s3_mode  <= s2_mode;
            s3_sof   <= s2_sof;
            s3_eol   <= s2_eol;
        end
    end

    gray_round_sat #(
        .IN_W  (S_W),
        .SH    (SH),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .value  (s3_sum),
        .result (rs_gray)
    );

    always_comb begin
        pick_gray = OUT_W'(s3_m >> MSH);
        if (s3_mode == MODE_WEIGHTED || s3_mode == MODE_AVG) begin
            pick_gray = rs_gray;
        end
    end

    // Output only moves when the downstream has taken the current pixel.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_gray  <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (advance) begin
            out_valid <= s3_valid;
            if (s3_valid) begin
                out_gray <= pick_gray;
                out_sof  <= s3_sof;
                out_eol  <= s3_eol;
            end
        end
    end

endmodule

// File: doc/color_to_grayscale_stream.md
Name: color_to_grayscale_stream

Overview:
Parametrised, fully pipelined RGB-to-grayscale converter for the video datapath, replacing the fixed single-register converter.
- Accepts one RGB pixel per cycle over a valid/ready stream and carries frame/line sideband.
- Supports programmable weights, four conversion modes, round-to-nearest and output saturation.
- Sits between the pixel source (camera/frame reader) and downstream grayscale consumers (filters, thresholding).

Parameters:
IN_W, 8, width of each input colour channel (R, G, B); range 4..16
OUT_W, 8, width of the grayscale output; must satisfy OUT_W <= IN_W
COEF_W, 8, width of each unsigned weight
COEF_FRAC, 8, fractional bits of each weight (weight 256 = 1.0 at the default)
DEF_R, 77, reset value of the R weight (BT.601 0.299)
DEF_G, 150, reset value of the G weight (BT.601 0.587)
DEF_B, 29, reset value of the B weight (BT.601 0.114)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
cfg_we  in  1  write pending configuration registers
cfg_mode  in  2  conversion mode: 0=weighted, 1=average, 2=max(R,G,B), 3=G passthrough
cfg_coef_r  in  COEF_W  pending R weight
cfg_coef_g  in  COEF_W  pending G weight
cfg_coef_b  in  COEF_W  pending B weight
in_valid  in  1  input pixel valid
in_ready  out  1  converter can accept a pixel
in_r, in_g, in_b  in  IN_W each  input channels
in_sof  in  1  first pixel of frame
in_eol  in  1  last pixel of line
out_valid  out  1  output pixel valid
out_ready  in  1  downstream accepts output
out_gray  out  OUT_W  grayscale result
out_sof  out  1  in_sof delayed with the pixel
out_eol  out  1  in_eol delayed with the pixel
active_mode  out  2  mode currently applied

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid, out_gray, out_sof, out_eol all clear to 0; active_mode clears to 0.
  - Pending and active weights load DEF_R/G/B; pending mode loads 0.
  - All pipeline valid bits clear; any in-flight pixels are discarded.
  - in_ready is 1 in the cycle after reset deasserts.
- Configuration:
  - cfg_we=1 writes the pending registers (mode and three weights) on that edge.
  - Pending values are copied to the active set only on an accepted pixel with in_sof=1 (in_valid & in_ready & in_sof).
  - That pixel and all later pixels use the new set. Writes made mid-frame never change the current frame.
  - If cfg_we and an accepted sof occur in the same cycle, the sof pixel uses the values being written.
- Handshake:
  - A transfer occurs on in_valid & in_ready, and likewise on out_valid & out_ready.
  - in_ready = !(out_valid & !out_ready). This is a global stall: every stage holds its contents while out_valid=1 and out_ready=0.
  - Pipeline bubbles (stages with valid=0) are allowed to advance during a stall only if this does not change the outputs.
  - out_valid, once asserted, must not drop and out_gray must not change until the output transfer completes.
- Pipeline (3 stages, latency 3 cycles from input transfer to out_valid when never stalled):
  - S1: register channels, sideband, and mode/weights. Form products P_r = R*cR, P_g = G*cG, P_b = B*cB, each IN_W+COEF_W bits.
  - S2: compute sum S = P_r + P_g + P_b with 2 guard bits. In mode 2, compute M = max(R,G,B); in mode 3, M = G.
  - S3, modes 0/1: shift by SH = COEF_FRAC + IN_W - OUT_W, adding 2^(SH-1) before the shift when SH>0. If the result exceeds 2^OUT_W - 1, saturate to 2^OUT_W - 1.
  - S3, modes 2/3: out_gray = M >> (IN_W - OUT_W), truncated.
- Mode 1 uses fixed weights 85, 85, 86 (scaled to COEF_FRAC), not the programmed weights.
- Throughput is one pixel per cycle with no internal bubbles.

Decomposition:
- Shared package color_pkg holds:
  - the mode encoding constants (MODE_WEIGHTED, MODE_AVG, MODE_MAX, MODE_GREEN);
  - the BT.601 default weights;
  - the average weights.
- One sub-module, gray_round_sat: a combinational round, shift and saturate function parametrised by input width, SH and OUT_W. It is instanced in S3.

Test Plan:
- Reset, defaults, IN_W=OUT_W=8, pixel R=G=B=200, out_ready=1 -> out_gray=200 exactly 3 cycles after acceptance.
- Pixel R=255, G=0, B=0 in mode 0 -> out_gray=77. Pixel R=0, G=0, B=255 -> 29. Results arrive back-to-back on consecutive cycles.
- Weights written as 255,255,255, then sof pixel 255,255,255 -> out_gray saturates to 255.
- Mode 2 pixel R=10, G=200, B=30 -> 200. Mode 3 on the same pixel -> 200. Mode 1 pixel R=30, G=60, B=90 -> 60.
- Mid-frame cfg_we writes mode 3; non-sof pixel R=255, G=0, B=0 -> still 77. Next sof pixel with the same RGB -> 0.
- Stream 16 pixels while holding out_ready low for 5 cycles mid-burst -> in_ready drops, out_gray is held stable, and no pixel is lost or duplicated. sof/eol stay aligned.
- rst pulsed with 3 pixels in flight -> out_valid=0 on the next cycle, no stale outputs, and active weights and mode return to defaults.
